// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronised frame deserialiser, byte FIFO and make/break key tracker.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames with bad odd parity are rejected.
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic       i_rd_en,
    output logic [7:0] o_data,
    output logic       o_ready,
    output logic       o_overflow,
    output logic       o_frame_err,
    output logic [7:0] o_key_code,
    output logic       o_key_down,
    output logic [7:0] o_key_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BREAK = 1'b1} state_t;

    function automatic logic odd_parity_ok(input logic [8:0] v);
        return ^v;
    endfunction

    logic [2:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic [9:0]    r_shift;
    logic [3:0]    r_bit_cnt;
    logic [TW-1:0] r_idle_cnt;
    logic          r_frame_err;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_overflow;

    state_t        r_state;
    state_t        w_state_nx;
    logic [7:0]    r_key_code;
    logic [7:0]    w_key_code_nx;
    logic          r_key_down;
    logic          w_key_down_nx;
    logic [7:0]    r_key_count;
    logic [7:0]    w_key_count_nx;

    logic          w_fall;
    logic          w_bit;
    logic          w_last;
    logic          w_par_ok;
    logic          w_frame_ok;
    logic          w_byte_valid;
    logic [7:0]    w_byte;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_fall = ~r_clk_sync[1] & r_clk_sync[2];
    assign w_bit  = r_dat_sync[1];
    assign w_last = w_fall & (r_bit_cnt == 4'd10);

`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok = odd_parity_ok(r_shift[9:1]);
`else
    assign w_par_ok = 1'b1;
`endif

    // r_shift[0] is the start bit; the stop bit is the one arriving on this edge.
    assign w_frame_ok   = ~r_shift[0] & w_bit & w_par_ok;
    assign w_byte_valid = w_last & w_frame_ok;
    assign w_byte       = r_shift[8:1];

    // Synchronisers; idle-high reset values keep reset release from faking an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
        end
    end

    // Deserialiser, frame check and inter-edge timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift     <= 10'd0;
            r_bit_cnt   <= 4'd0;
            r_idle_cnt  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_last & ~w_frame_ok;
            if (w_fall) begin
                r_idle_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= 4'd0;
                end else begin
                    r_shift   <= {w_bit, r_shift[9:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_idle_cnt == TIMEOUT_C) begin
                r_bit_cnt <= 4'd0;
            end else begin
                r_idle_cnt <= r_idle_cnt + {{(TW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_rd_en & ~w_empty;
    assign w_push  = w_byte_valid & (~w_full | w_pop);

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_byte;
        end
    end

    // FIFO pointers and sticky overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_byte_valid & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Key tracker state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_key_code  <= 8'd0;
            r_key_down  <= 1'b0;
            r_key_count <= 8'd0;
        end else begin
            r_state     <= w_state_nx;
            r_key_code  <= w_key_code_nx;
            r_key_down  <= w_key_down_nx;
            r_key_count <= w_key_count_nx;
        end
    end

    // Key tracker next state: 0xF0 arms a release, 0xE0 prefix is transparent.
    always_comb begin
        w_state_nx     = r_state;
        w_key_code_nx  = r_key_code;
        w_key_down_nx  = r_key_down;
        w_key_count_nx = r_key_count;
        case (r_state)
            ST_IDLE: begin
                if (!w_byte_valid) begin
                    w_state_nx = ST_IDLE;
                end else if (w_byte == 8'hF0) begin
                    w_state_nx = ST_BREAK;
                end else if (w_byte == 8'hE0) begin
                    w_state_nx = ST_IDLE;
                end else if (!r_key_down || (w_byte != r_key_code)) begin
                    w_key_code_nx  = w_byte;
                    w_key_down_nx  = 1'b1;
                    w_key_count_nx = r_key_count + 8'd1;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (w_byte_valid) begin
                    w_state_nx = ST_IDLE;
                    if (w_byte == r_key_code) begin
                        w_key_down_nx = 1'b0;
                    end else begin
                        w_key_down_nx = r_key_down;
                    end
                end else begin
                    w_state_nx = ST_BREAK;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign o_data      = r_mem[r_rd_ptr[AW-1:0]];
    assign o_ready     = ~w_empty;
    assign o_overflow  = r_overflow;
    assign o_frame_err = r_frame_err;
    assign o_key_code  = r_key_code;
    assign o_key_down  = r_key_down;
    assign o_key_count = r_key_count;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed self-checking bench for ps2_keyboard_rx; expectations follow PS2_PARITY_CHECK_EN if defined.
module tb_ps2_keyboard_rx;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;
    logic [7:0] key_code;
    logic       key_down;
    logic [7:0] key_count;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int err_base;

    ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .i_rd_en    (rd_en),
        .o_data     (data),
        .o_ready    (ready),
        .o_overflow (overflow),
        .o_frame_err(frame_err),
        .o_key_code (key_code),
        .o_key_down (key_down),
        .o_key_count(key_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip);
        logic par;
        par = ~(^b) ^ flip;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (8) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0), 11);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] want);
        @(negedge clk);
        check({tag, "_ready"}, 32'(ready), 32'h1);
        check(tag, 32'(data), 32'(want));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0]  seq5 [5];
        logic [10:0] f;
        seq5 = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};

        do_reset();
        check("rst_ready",     32'(ready),     32'h0);
        check("rst_overflow",  32'(overflow),  32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_key_code",  32'(key_code),  32'h0);
        check("rst_key_down",  32'(key_down),  32'h0);
        check("rst_key_count", 32'(key_count), 32'h0);

        // Single byte and pop
        send_byte(8'h1C);
        check("one_code",  32'(key_code),  32'h1C);
        check("one_down",  32'(key_down),  32'h1);
        check("one_count", 32'(key_count), 32'h1);
        pop_expect("one_data", 8'h1C);
        check("one_empty", 32'(ready), 32'h0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("empty_pop_ignored", 32'(ready), 32'h0);

        // Typematic repeat then release
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(seq5[i]);
        check("rep_count", 32'(key_count), 32'h1);
        check("rep_down",  32'(key_down),  32'h0);
        check("rep_code",  32'(key_code),  32'h1C);
        for (int i = 0; i < 5; i++) pop_expect("rep_data", seq5[i]);
        check("rep_empty", 32'(ready), 32'h0);

        // Overflow
        do_reset();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_byte(8'(i));
            if (i == DEPTH) check("ovf_not_yet", 32'(overflow), 32'h0);
        end
        check("ovf_set",   32'(overflow),  32'h1);
        check("ovf_count", 32'(key_count), 32'h9);
        check("ovf_code",  32'(key_code),  32'h9);
        for (int i = 1; i <= DEPTH; i++) pop_expect("ovf_data", 8'(i));
        check("ovf_empty",  32'(ready),    32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // E0 prefix and release of a different key
        do_reset();
        send_byte(8'hE0);
        check("e0_count", 32'(key_count), 32'h0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h2A);
        check("brk_other_down", 32'(key_down),  32'h1);
        check("brk_other_code", 32'(key_code),  32'h1C);
        check("brk_other_cnt",  32'(key_count), 32'h1);
        send_byte(8'h2A);
        check("new_key_code",  32'(key_code),  32'h2A);
        check("new_key_count", 32'(key_count), 32'h2);

        // Parity flip
        do_reset();
        err_base = err_cnt;
        send_bits(mk_frame(8'h1C, 1'b1), 11);
        repeat (8) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err",   32'(err_cnt - err_base), 32'h1);
        check("par_ready", 32'(ready),              32'h0);
        check("par_count", 32'(key_count),          32'h0);
`else
        check("par_err",   32'(err_cnt - err_base), 32'h0);
        check("par_ready", 32'(ready),              32'h1);
        check("par_data",  32'(data),               32'h1C);
        check("par_count", 32'(key_count),          32'h1);
`endif

        // Bad stop bit and bad start bit
        do_reset();
        err_base = err_cnt;
        f = mk_frame(8'h33, 1'b0);
        f[10] = 1'b0;
        send_bits(f, 11);
        repeat (20) @(negedge clk);
        check("stop_err", 32'(err_cnt - err_base), 32'h1);
        f = mk_frame(8'h33, 1'b0);
        f[0] = 1'b1;
        send_bits(f, 11);
        repeat (20) @(negedge clk);
        check("start_err",   32'(err_cnt - err_base), 32'h2);
        check("bad_ready",   32'(ready),              32'h0);
        check("bad_count",   32'(key_count),          32'h0);

        // Timeout discards a partial frame
        do_reset();
        err_base = err_cnt;
        send_bits(mk_frame(8'h5A, 1'b0), 6);
        repeat (TMO + 20) @(negedge clk);
        send_byte(8'h32);
        check("tmo_err",  32'(err_cnt - err_base), 32'h0);
        check("tmo_code", 32'(key_code),           32'h32);
        pop_expect("tmo_data", 8'h32);
        check("tmo_empty", 32'(ready), 32'h0);

        // Reset in the middle of a frame
        do_reset();
        send_bits(mk_frame(8'h55, 1'b0), 5);
        do_reset();
        check("midrst_ready", 32'(ready), 32'h0);
        send_byte(8'h24);
        check("midrst_count", 32'(key_count), 32'h1);
        pop_expect("midrst_data", 8'h24);
        check("midrst_empty", 32'(ready), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver. It deserialises 11-bit frames from an asynchronous PS/2 clock/data pair and buffers the received bytes in a small FIFO. It also tracks make/break codes so the top level can show the current key and a press count on the seven-segment displays. It is the input-side counterpart to the display top levels: it produces the values that the display encoders consume.

## Interface
- FIFO_DEPTH, 8: byte FIFO entries; power of two, at least 2.
- TIMEOUT, 50000: `clk` cycles without a PS/2 falling edge before a partial frame is discarded.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  asynchronous PS/2 clock from the device.
- ps2_data  in  1  asynchronous PS/2 data from the device.
- rd_en  in  1  pop strobe; consumes `data` when `ready` is high.
- data  out  8  FIFO head byte; valid while `ready` is high.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky; set when a valid byte arrives with the FIFO full; cleared only by `rst`.
- frame_err  out  1  one-cycle pulse on a rejected frame.
- key_code  out  8  last make code accepted by the tracker.
- key_down  out  1  `key_code` is currently held.
- key_count  out  8  number of distinct presses, modulo 256.

## Operation
- **Synchroniser and edge detect**
  - `ps2_clk` passes through 3 flops and `ps2_data` through 2 flops.
  - A falling edge is detected when stage 2 = 0 and stage 3 = 1.
- **Deserialiser**
  - On each detected edge, sample synced `ps2_data` into a 10-bit shift register, LSB first; bit counter runs 0..10.
  - On the edge where the counter = 10, check the frame and clear the counter to 0.
  - Frame checks: start bit = 0, stop bit = 1, odd parity over 8 data bits plus the parity bit.
  - A passing frame gives a valid byte. A failing frame is dropped and `frame_err` pulses.
- **Timeout**
  - A counter counts cycles since the last edge.
  - If it reaches TIMEOUT while the bit counter is non-zero, the bit counter clears to 0 and the partial frame is dropped silently.
- **FIFO**
  - Circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH); `data` = mem[rd_ptr] (combinational).
  - Push on a valid byte. If full and no pop in the same cycle: drop the byte, set `overflow`.
  - Pop on `rd_en` & `ready`. `rd_en` while empty is ignored.
  - Push and pop in the same cycle are both performed. When full this is not an overflow; when empty the pop is ignored and the push proceeds.
- **Key tracker**
  - Sees every valid byte, including bytes dropped by the FIFO.
  - States: IDLE, BREAK.
  - IDLE, byte 0xF0: go to BREAK.
  - IDLE, byte 0xE0: ignore, stay IDLE.
  - IDLE, any other byte, when `key_down`=0 or byte ≠ `key_code`: `key_code` ← byte, `key_down` ← 1, `key_count` += 1 (wraps 0xFF→0x00).
  - IDLE, byte = `key_code` with `key_down`=1 (typematic repeat): no change.
  - BREAK, any byte: if byte = `key_code`, `key_down` ← 0; return to IDLE in all cases. The byte never counts as a press.

## Timing
- **Reset values:** `data` undefined (ignore while `ready`=0). Every other output is 0, along with the counters, pointers, tracker state (IDLE) and shift register.
- **Edge latency:** a `ps2_clk` falling edge is detected 3 `clk` cycles after it reaches the first synchroniser flop.
- **Frame latency:** `ready`, the tracker outputs and `frame_err` update on the cycle after the 11th edge is detected.
- **Pop:** `ready` and `data` reflect a pop on the next cycle.
- **Reset mid-frame:** the partial frame is discarded. Reception restarts from the next falling edge, treated as a start bit.
- PS/2 clock rate (10–16.7 kHz) is assumed to be at least 8× slower than `clk`.

## Configuration
- `PS2_PARITY_CHECK_EN`
  - Defined: a frame with bad parity is rejected, `frame_err` pulses, and neither the FIFO nor the tracker sees the byte.
  - Undefined: the parity bit is shifted in but ignored; only start and stop bits are checked.

## Test plan
- Send a valid frame for byte 0x1C, then assert `rd_en` once → `ready`=1 with `data`=0x1C; `key_code`=0x1C, `key_down`=1, `key_count`=1; after the pop, `ready`=0.
- Send 0x1C, 0x1C, 0x1C, 0xF0, 0x1C → `key_count`=1, final `key_down`=0, FIFO holds 5 bytes.
- Send FIFO_DEPTH+1 frames (bytes 0x01..0x09) with no reads → `overflow`=1; reads return 0x01..0x08 in order; 0x09 is lost.
- With `PS2_PARITY_CHECK_EN` defined, send 0x1C with the parity bit flipped → one `frame_err` pulse, `ready`=0, tracker unchanged. Without the macro → byte accepted.
- Send 6 bits, idle TIMEOUT+1 cycles, then send a full 0x32 frame → only 0x32 received, no `frame_err`.
- Assert `rst` after 5 bits of a frame, then send a full 0x24 frame → `data`=0x24 and `key_count`=1.
